// File: rtl/if_id_stage.sv
// if_id_stage
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Owns the fetch PC, picks the next PC (sequential / EX redirect / hold),
// drives the instruction-memory address and registers the fetched word into
// decode, breaking out the fields the decode controller consumes.
//
// Ports
//   clk, reset          core clock, asynchronous active-high reset
//   StallF, StallD      hold PC / hold IF/ID register
//   FlushD              load a bubble into IF/ID
//   PCSrcE, JalrE       redirect request from EX, redirect is a JALR
//   PCTargetE           redirect target from EX
//   InstrRdata          combinational instruction-memory read data
//   InstrAddr, PCF      fetch address / fetch PC (identical)
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register contents
//   opD, funct3D, funct7b5D, Rs1D, Rs2D, RdD   slices of InstrD
//   MisalignTrap        sticky flag: a redirect target was misaligned
//
// State | meaning
// RUN   | normal fetch
// HALT  | misaligned redirect seen; PC frozen, bubbles only, left by reset
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic        JalrE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrRdata,
    output logic [31:0] InstrAddr,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [6:0]  opD,
    output logic [2:0]  funct3D,
    output logic        funct7b5D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic        MisalignTrap
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [31:0] target;
    logic        target_misaligned;
    logic [31:0] pc_plus4;

    // JALR clears bit 0, so only a plain branch/jump can trap on bit 0.
    assign target            = JalrE ? {PCTargetE[31:1], 1'b0} : PCTargetE;
    assign target_misaligned = |target[1:0];
    assign pc_plus4          = PCF + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            PCF          <= RESET_PC;
            InstrD       <= NOP_INSTR;
            PCD          <= 32'd0;
            PCPlus4D     <= 32'd0;
            ValidD       <= 1'b0;
            MisalignTrap <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (PCSrcE && target_misaligned) begin
                        state        <= HALT;
                        MisalignTrap <= 1'b1;
                        InstrD       <= NOP_INSTR;
                        PCD          <= 32'd0;
                        PCPlus4D     <= 32'd0;
                        ValidD       <= 1'b0;
                    end else begin
                        // a resolved redirect wins over a fetch stall
                        if (PCSrcE)
                            PCF <= target;
                        else if (!StallF)
                            PCF <= pc_plus4;

                        if (FlushD) begin
                            InstrD   <= NOP_INSTR;
                            PCD      <= 32'd0;
                            PCPlus4D <= 32'd0;
                            ValidD   <= 1'b0;
                        end else if (!StallD) begin
                            InstrD   <= InstrRdata;
                            PCD      <= PCF;
                            PCPlus4D <= pc_plus4;
                            ValidD   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    MisalignTrap <= 1'b1;
                    InstrD       <= NOP_INSTR;
                    PCD          <= 32'd0;
                    PCPlus4D     <= 32'd0;
                    ValidD       <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign InstrAddr = PCF;
    assign opD       = InstrD[6:0];
    assign funct3D   = InstrD[14:12];
    assign funct7b5D = InstrD[30];
    assign Rs1D      = InstrD[19:15];
    assign Rs2D      = InstrD[24:20];
    assign RdD       = InstrD[11:7];

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE, JalrE;
    logic [31:0] PCTargetE, InstrRdata, InstrAddr, PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, funct7b5D, MisalignTrap;
    logic [6:0]  opD;
    logic [2:0]  funct3D;
    logic [4:0]  Rs1D, Rs2D, RdD;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
    logic        m_valid, m_trap, m_halted;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    // memory: word i holds i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    assign InstrRdata = mem_word(InstrAddr);

    if_id_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcE(PCSrcE), .JalrE(JalrE), .PCTargetE(PCTargetE),
        .InstrRdata(InstrRdata), .InstrAddr(InstrAddr), .PCF(PCF),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D), .Rs1D(Rs1D),
        .Rs2D(Rs2D), .RdD(RdD), .MisalignTrap(MisalignTrap)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = NOP; m_pcd = 0; m_pc4d = 0;
        m_valid = 0; m_trap = 0; m_halted = 0;
    endtask

    task automatic bubble();
        m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
    endtask

    // one clock edge of the specified behaviour
    task automatic model_clock(input logic sf, sd, fd, ps, jr, input logic [31:0] tgt);
        logic [31:0] t;
        logic [31:0] fetched;
        fetched = mem_word(m_pc);
        t = jr ? (tgt & 32'hFFFF_FFFE) : tgt;
        if (m_halted) begin
            bubble();
        end else if (ps && (t % 4 != 0)) begin
            m_halted = 1; m_trap = 1;
            bubble();
        end else begin
            if (fd) bubble();
            else if (!sd) begin
                m_instr = fetched; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1;
            end
            if (ps) m_pc = t;
            else if (!sf) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check_eq("PCF", PCF, m_pc);
        check_eq("InstrAddr", InstrAddr, m_pc);
        check_eq("InstrD", InstrD, m_instr);
        check_eq("PCD", PCD, m_pcd);
        check_eq("PCPlus4D", PCPlus4D, m_pc4d);
        check_eq("ValidD", 32'(ValidD), 32'(m_valid));
        check_eq("MisalignTrap", 32'(MisalignTrap), 32'(m_trap));
        check_eq("opD", 32'(opD), 32'(m_instr[6:0]));
        check_eq("funct3D", 32'(funct3D), 32'(m_instr[14:12]));
        check_eq("funct7b5D", 32'(funct7b5D), 32'(m_instr[30]));
        check_eq("Rs1D", 32'(Rs1D), 32'(m_instr[19:15]));
        check_eq("Rs2D", 32'(Rs2D), 32'(m_instr[24:20]));
        check_eq("RdD", 32'(RdD), 32'(m_instr[11:7]));
    endtask

    // called at posedge+1; drives inputs, clocks once, checks at posedge+1
    task automatic step(input logic sf, sd, fd, ps, jr, input logic [31:0] tgt);
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; JalrE = jr; PCTargetE = tgt;
        @(posedge clk);
        model_clock(sf, sd, fd, ps, jr, tgt);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        reset = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; JalrE = 0; PCTargetE = 0;
        model_reset();
        #2;
        compare_all();
        @(posedge clk); #1;
        compare_all();
        reset = 0;

        // sequential fetch from 0 up to PCF = 0x10
        idle(4);
        check_eq("seq_pc_0x10", PCF, 32'h10);
        // stall both for three cycles, then resume
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 32'd0);
        idle(1);
        check_eq("resume_pc", PCF, 32'h14);
        idle(2);
        check_eq("seq_pc_0x1c", PCF, 32'h1c);
        idle(1);
        // branch from 0x20 to 0x100 with flush
        step(0, 0, 1, 1, 0, 32'h100);
        check_eq("branch_bubble_op", 32'(opD), 32'h13);
        check_eq("branch_pc", PCF, 32'h100);
        idle(1);
        check_eq("branch_target_pcd", PCD, 32'h100);
        // StallF-only re-presents the same PC
        step(1, 0, 0, 0, 0, 32'd0);
        step(1, 0, 0, 0, 0, 32'd0);
        // redirect overrides StallF
        step(1, 0, 1, 1, 0, 32'h40);
        check_eq("redirect_over_stall", PCF, 32'h40);
        // flush and stall together: flush wins
        step(0, 1, 1, 0, 0, 32'd0);
        // JALR clears bit 0
        step(0, 0, 1, 1, 1, 32'h205);
        check_eq("jalr_pc", PCF, 32'h204);
        check_eq("jalr_no_trap", 32'(MisalignTrap), 32'd0);
        idle(1);
        // PC wraps at the top of the address space
        step(0, 0, 1, 1, 0, 32'hFFFF_FFFC);
        idle(2);
        check_eq("wrap_pc", PCF, 32'h4);

        // randomized phase, aligned redirects only
        for (int i = 0; i < 400; i++) begin
            logic ps, jr;
            logic [31:0] tgt;
            ps  = ($urandom_range(0, 7) == 0);
            jr  = $urandom_range(0, 1) == 1;
            tgt = $urandom & 32'hFFFF_FFFC;
            if (jr) tgt[0] = $urandom_range(0, 1) == 1;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 ps ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
                 ps, jr, tgt);
        end

        // misaligned non-JALR redirect -> HALT
        step(0, 0, 0, 1, 0, 32'h202);
        check_eq("trap_set", 32'(MisalignTrap), 32'd1);
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC);
        check_eq("halt_valid", 32'(ValidD), 32'd0);

        // asynchronous reset in the middle of a cycle while halted
        #2;
        reset = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); #1;
        compare_all();
        reset = 0;
        idle(3);
        check_eq("restart_pc", PCF, 32'hc);

        // a second misaligned case: JALR with bit 1 set
        step(0, 0, 1, 1, 1, 32'h0000_0303);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
